// File: rtl/large_adder_pipe.sv
`timescale 1ns/1ps
// Three-stage byte-difference multiply/add datapath with a signed accumulator
// and sticky overflow; valid/ready handshake at both ends with a global stall.
module large_adder_pipe #(
  parameter int WIDTH = 32,
  localparam int OUT_W = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       mode,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] data_out,
  output logic             ovf
);

  localparam int BYTE_W = 8;
  localparam int NBYTES = WIDTH / BYTE_W;
  localparam int HALF_W = WIDTH / 2;

  typedef enum logic [1:0] {
    MODE_PS  = 2'd0,
    MODE_P   = 2'd1,
    MODE_ACC = 2'd2,
    MODE_S   = 2'd3
  } mode_e;

  // Upper-half byte sum minus lower-half byte sum, already in OUT_W two's complement.
  function automatic logic [OUT_W-1:0] byte_half_diff(input logic [WIDTH-1:0] d);
    logic [OUT_W-1:0] r;
    r = {OUT_W{1'b0}};
    for (int i = 0; i < NBYTES; i++) begin
      if (i >= NBYTES / 2) begin
        r = r + OUT_W'(d[i*BYTE_W +: BYTE_W]);
      end else begin
        r = r - OUT_W'(d[i*BYTE_W +: BYTE_W]);
      end
    end
    return r;
  endfunction

  function automatic logic add_ovf(input logic [OUT_W-1:0] a,
                                   input logic [OUT_W-1:0] b,
                                   input logic [OUT_W-1:0] r);
    return (a[OUT_W-1] == b[OUT_W-1]) && (r[OUT_W-1] != a[OUT_W-1]);
  endfunction

  logic             stall_s;
  logic             accept_s;
  logic             load3_s;
  logic [OUT_W-1:0] a_s;
  logic [OUT_W-1:0] d_s;
  logic [OUT_W-1:0] s_s;
  logic [OUT_W-1:0] p_s;

  logic             s1_valid_r;
  logic [OUT_W-1:0] s1_a_r;
  logic [OUT_W-1:0] s1_d_r;
  logic [OUT_W-1:0] s1_s_r;
  mode_e            s1_mode_r;

  logic             s2_valid_r;
  logic [OUT_W-1:0] s2_p_r;
  logic [OUT_W-1:0] s2_s_r;
  mode_e            s2_mode_r;

  logic [OUT_W-1:0] acc_r;
  logic [OUT_W-1:0] acc_base_s;
  logic [OUT_W-1:0] sum1_s;
  logic [OUT_W-1:0] sum2_s;
  logic [OUT_W-1:0] result_s;
  logic             acc_ovf_s;

  logic             out_valid_r;
  logic [OUT_W-1:0] data_out_r;
  logic             ovf_r;

  assign out_valid = out_valid_r;
  assign data_out  = data_out_r;
  assign ovf       = ovf_r;

  // Handshake: a result held at the output freezes the whole pipe.
  always_comb begin
    stall_s  = out_valid_r && !out_ready;
    in_ready = rst_n && !stall_s;
    accept_s = in_valid && in_ready;
    load3_s  = s2_valid_r && !stall_s;
  end

  // Operand formation for S1 and the S2 product.
  always_comb begin
    a_s = byte_half_diff(data_in);
    d_s = OUT_W'(data_in[WIDTH-1:HALF_W]) - OUT_W'(data_in[HALF_W-1:0]);
    s_s = OUT_W'(data_in[WIDTH-1:HALF_W]) + OUT_W'(data_in[HALF_W-1:0]);
    p_s = OUT_W'($signed(s1_a_r) * $signed(s1_d_r));
  end

  // S3 result select; a same-cycle clear restarts accumulation from zero.
  always_comb begin
    if (acc_clr) begin
      acc_base_s = {OUT_W{1'b0}};
    end else begin
      acc_base_s = acc_r;
    end
    sum1_s    = acc_base_s + s2_p_r;
    sum2_s    = sum1_s + s2_s_r;
    acc_ovf_s = add_ovf(acc_base_s, s2_p_r, sum1_s) || add_ovf(sum1_s, s2_s_r, sum2_s);
    case (s2_mode_r)
      MODE_PS:  result_s = s2_p_r + s2_s_r;
      MODE_P:   result_s = s2_p_r;
      MODE_ACC: result_s = sum2_s;
      MODE_S:   result_s = s2_s_r;
      default:  result_s = s2_p_r + s2_s_r;
    endcase
  end

  // Stage 1 register: captures operands of an accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= {OUT_W{1'b0}};
      s1_d_r     <= {OUT_W{1'b0}};
      s1_s_r     <= {OUT_W{1'b0}};
      s1_mode_r  <= MODE_PS;
    end else if (!stall_s) begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_a_r    <= a_s;
        s1_d_r    <= d_s;
        s1_s_r    <= s_s;
        s1_mode_r <= mode_e'(mode);
      end
    end
  end

  // Stage 2 register: product plus forwarded sum and mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_p_r     <= {OUT_W{1'b0}};
      s2_s_r     <= {OUT_W{1'b0}};
      s2_mode_r  <= MODE_PS;
    end else if (!stall_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_p_r    <= p_s;
        s2_s_r    <= s1_s_r;
        s2_mode_r <= s1_mode_r;
      end
    end
  end

  // Stage 3 register: bubbles leave the last result on data_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      data_out_r  <= {OUT_W{1'b0}};
    end else if (!stall_s) begin
      out_valid_r <= s2_valid_r;
      if (s2_valid_r) begin
        data_out_r <= result_s;
      end
    end
  end

  // Accumulator and sticky overflow; only mode-2 loads or a clear touch them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= {OUT_W{1'b0}};
      ovf_r <= 1'b0;
    end else if (load3_s && (s2_mode_r == MODE_ACC)) begin
      acc_r <= sum2_s;
      ovf_r <= (ovf_r && !acc_clr) || acc_ovf_s;
    end else if (acc_clr) begin
      acc_r <= {OUT_W{1'b0}};
      ovf_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_large_adder_pipe.sv
`timescale 1ns/1ps
// Scoreboard bench: a 32-bit instance for the datapath, handshake and reset,
// and a 16-bit instance whose accumulator can be driven into overflow quickly.
module tb_large_adder_pipe;

  typedef struct packed {
    logic [63:0] data;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready, acc_clr, out_valid, out_ready, ovf;
  logic [31:0] data_in;
  logic [1:0]  mode;
  logic [63:0] data_out;

  logic        in_valid16, in_ready16, acc_clr16, out_valid16, out_ready16, ovf16;
  logic [15:0] data_in16;
  logic [1:0]  mode16;
  logic [31:0] data_out16;

  int   checks = 0;
  int   fails  = 0;
  exp_t sb[$];
  exp_t sb16[$];

  large_adder_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .mode(mode), .acc_clr(acc_clr), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .ovf(ovf)
  );

  large_adder_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .data_in(data_in16), .mode(mode16), .acc_clr(acc_clr16), .out_valid(out_valid16),
    .out_ready(out_ready16), .data_out(data_out16), .ovf(ovf16)
  );

  always #5 clk = ~clk;

  // Reference for modes 0/1/3 on a 32-bit sample, plain integer arithmetic.
  function automatic logic [63:0] model_out(input logic [31:0] d, input logic [1:0] m);
    longint a, dd, s, p;
    a  = longint'(d[31:24]) + longint'(d[23:16]) - longint'(d[15:8]) - longint'(d[7:0]);
    dd = longint'(d[31:16]) - longint'(d[15:0]);
    s  = longint'(d[31:16]) + longint'(d[15:0]);
    p  = a * dd;
    case (m)
      2'd1:    return 64'(p);
      2'd3:    return 64'(s);
      default: return 64'(p + s);
    endcase
  endfunction

  task automatic drive_one(input logic [31:0] d, input logic [1:0] m, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; data_in = d; mode = m;
    while (!ok && n < 20) begin
      #4;
      ok = (in_ready === 1'b1);
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit got, output int lat);
    got = 1'b0;
    lat = 0;
    while (!got && lat < 20) begin
      if (out_valid === 1'b1) got = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (data_out !== 64'h0) begin fails++; $display("FAIL reset_data_out: got %h want 0", data_out); end
    checks++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    checks++; if (out_valid16 !== 1'b0) begin fails++; $display("FAIL reset_out_valid16: got %b want 0", out_valid16); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_modes();
    logic [31:0] vd [8] = '{32'h04030201, 32'h00010002, 32'h00010002, 32'h00010002,
                            32'h04030201, 32'h04030201, 32'h01000002, 32'h0000FFFF};
    logic [1:0]  vm [8] = '{2'd0, 2'd0, 2'd1, 2'd3, 2'd1, 2'd3, 2'd1, 2'd0};
    bit ok, got;
    int lat;
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      sb.push_back('{model_out(vd[i], vm[i]), 1'b0});
      drive_one(vd[i], vm[i], ok);
      checks++; if (!ok) begin fails++; $display("FAIL modes_accept[%0d]: in_ready never 1", i); end
      wait_out(got, lat);
      if (sb.size() > 0) e = sb.pop_front(); else e = '1;
      checks++;
      if (!got) begin fails++; $display("FAIL modes_timeout[%0d]: no out_valid", i); end
      else if (data_out !== e.data || ovf !== e.ovf) begin
        fails++; $display("FAIL modes_data[%0d]: got %h/%b want %h/%b", i, data_out, ovf, e.data, e.ovf);
      end
      if (i == 0) begin
        checks++; if (lat !== 2) begin fails++; $display("FAIL latency: got %0d want 2 negedges after capture", lat); end
        checks++; if (data_out !== 64'h0000000000000E0C) begin fails++; $display("FAIL known_vector: got %h want 0e0c", data_out); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_pulse: out_valid %b want 0", out_valid); end
        checks++; if (data_out !== 64'hE0C) begin fails++; $display("FAIL bubble_hold: got %h want 0e0c", data_out); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vd [8];
    logic [1:0]  vm [8];
    int got;
    for (int i = 0; i < 8; i++) begin
      vd[i] = $urandom;
      vm[i] = (i % 3 == 0) ? 2'd0 : ((i % 3 == 1) ? 2'd1 : 2'd3);
    end
    got = 0;
    fork
      begin : drv
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          bit acc_ok;
          int n;
          acc_ok = 1'b0; n = 0;
          in_valid = 1'b1; data_in = vd[i]; mode = vm[i];
          while (!acc_ok && n < 20) begin
            #4;
            if (in_ready === 1'b1) begin
              acc_ok = 1'b1;
              sb.push_back('{model_out(vd[i], vm[i]), 1'b0});
            end
            @(negedge clk);
            n++;
          end
          if (!acc_ok) begin checks++; fails++; $display("FAIL b2b_accept[%0d]: not accepted", i); end
        end
        in_valid = 1'b0;
      end
      begin : col
        bit tog, held_v;
        logic [63:0] held;
        exp_t e;
        int n;
        tog = 1'b1; held_v = 1'b0; held = 64'h0; n = 0;
        while (got < 8 && n < 200) begin
          @(negedge clk);
          n++;
          if (held_v) begin
            checks++;
            if (out_valid !== 1'b1 || data_out !== held) begin
              fails++; $display("FAIL stall_hold: got %b/%h want 1/%h", out_valid, data_out, held);
            end
          end
          out_ready = tog;
          tog = !tog;
          held_v = 1'b0;
          if (out_valid === 1'b1) begin
            if (out_ready) begin
              if (sb.size() > 0) e = sb.pop_front(); else e = '1;
              checks++;
              if (data_out !== e.data) begin fails++; $display("FAIL b2b_data[%0d]: got %h want %h", got, data_out, e.data); end
              got++;
            end else begin
              held_v = 1'b1;
              held = data_out;
            end
          end
        end
        out_ready = 1'b1;
        if (got < 8) begin checks++; fails++; $display("FAIL b2b_timeout: got %0d results want 8", got); end
      end
    join
    begin
      int extra;
      extra = 0;
      repeat (5) begin @(negedge clk); if (out_valid === 1'b1) extra++; end
      checks++; if (extra != 0) begin fails++; $display("FAIL b2b_duplicate: %0d extra outputs want 0", extra); end
      checks++; if (sb.size() != 0) begin fails++; $display("FAIL b2b_left: %0d pending want 0", sb.size()); end
    end
  endtask

  task automatic test_accumulate();
    logic [63:0] expc [3] = '{64'hE0C, 64'h1C18, 64'h2A24};
    logic [1:0]  om [3]   = '{2'd0, 2'd1, 2'd3};
    bit ok, got;
    int lat;
    exp_t e;
    out_ready = 1'b1;
    @(negedge clk); acc_clr = 1'b1;
    @(negedge clk); acc_clr = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i < 3) sb.push_back('{expc[i], 1'b0});
      else if (i < 6) sb.push_back('{model_out(32'h00010002, om[i-3]), 1'b0});
      else sb.push_back('{64'h3830, 1'b0});
      if (i >= 3 && i < 6) drive_one(32'h00010002, om[i-3], ok);
      else drive_one(32'h04030201, 2'd2, ok);
      wait_out(got, lat);
      if (sb.size() > 0) e = sb.pop_front(); else e = '1;
      checks++;
      if (!got || data_out !== e.data || ovf !== e.ovf) begin
        fails++; $display("FAIL acc_seq[%0d]: got %b %h/%b want %h/%b", i, got, data_out, ovf, e.data, e.ovf);
      end
    end
    // Clear lands on the same edge the mode-2 sample enters S3.
    sb.push_back('{64'hE0C, 1'b0});
    drive_one(32'h04030201, 2'd2, ok);
    @(negedge clk); acc_clr = 1'b1;
    @(negedge clk); acc_clr = 1'b0;
    if (sb.size() > 0) e = sb.pop_front(); else e = '1;
    checks++;
    if (out_valid !== 1'b1 || data_out !== e.data || ovf !== e.ovf) begin
      fails++; $display("FAIL acc_clr_coincident: got %b %h/%b want 1 %h/%b", out_valid, data_out, ovf, e.data, e.ovf);
    end
    for (int i = 0; i < 2; i++) begin
      if (i == 1) begin
        @(negedge clk); acc_clr = 1'b1;
        @(negedge clk); acc_clr = 1'b0;
      end
      sb.push_back('{(i == 0) ? 64'h1C18 : 64'hE0C, 1'b0});
      drive_one(32'h04030201, 2'd2, ok);
      wait_out(got, lat);
      if (sb.size() > 0) e = sb.pop_front(); else e = '1;
      checks++;
      if (!got || data_out !== e.data || ovf !== e.ovf) begin
        fails++; $display("FAIL acc_after_clr[%0d]: got %b %h/%b want %h/%b", i, got, data_out, ovf, e.data, e.ovf);
      end
    end
  endtask

  task automatic test_overflow16();
    localparam int NS = 32900;
    logic [63:0] total;
    logic [31:0] tail_d [3] = '{32'd65280, 32'd65025, 32'd255};
    logic [1:0]  tail_m [3] = '{2'd0, 2'd1, 2'd3};
    bit ovf_exp;
    int got;
    total = 64'h0; ovf_exp = 1'b0; got = 0;
    out_ready16 = 1'b1;
    fork
      begin : drv16
        for (int i = 0; i < NS + 3; i++) begin
          @(negedge clk);
          in_valid16 = 1'b1; data_in16 = 16'hFF00;
          if (i < NS) begin
            mode16 = 2'd2;
            total = total + 64'd65280;
            if (total > 64'd2147483647) ovf_exp = 1'b1;
            sb16.push_back('{{32'h0, total[31:0]}, ovf_exp});
          end else begin
            mode16 = tail_m[i-NS];
            sb16.push_back('{{32'h0, tail_d[i-NS]}, ovf_exp});
          end
        end
        @(negedge clk);
        in_valid16 = 1'b0;
      end
      begin : col16
        exp_t e;
        int n;
        n = 0;
        while (got < NS + 3 && n < NS + 100) begin
          @(negedge clk);
          n++;
          if (out_valid16 === 1'b1) begin
            if (sb16.size() > 0) e = sb16.pop_front(); else e = '1;
            checks++;
            if (data_out16 !== e.data[31:0] || ovf16 !== e.ovf) begin
              fails++; $display("FAIL ovf16_stream[%0d]: got %h/%b want %h/%b", got, data_out16, ovf16, e.data[31:0], e.ovf);
            end
            got++;
          end
        end
        if (got < NS + 3) begin checks++; fails++; $display("FAIL ovf16_timeout: got %0d want %0d", got, NS + 3); end
      end
    join
    repeat (3) @(negedge clk);
    checks++; if (ovf16 !== 1'b1) begin fails++; $display("FAIL ovf16_sticky: got %b want 1", ovf16); end
    acc_clr16 = 1'b1;
    @(negedge clk); acc_clr16 = 1'b0;
    checks++; if (ovf16 !== 1'b0) begin fails++; $display("FAIL ovf16_clear: got %b want 0", ovf16); end
    begin
      exp_t e;
      int n;
      sb16.push_back('{64'd65280, 1'b0});
      in_valid16 = 1'b1; mode16 = 2'd2; data_in16 = 16'hFF00;
      @(negedge clk); in_valid16 = 1'b0;
      n = 0;
      while (out_valid16 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      if (sb16.size() > 0) e = sb16.pop_front(); else e = '1;
      checks++;
      if (out_valid16 !== 1'b1 || data_out16 !== e.data[31:0] || ovf16 !== e.ovf) begin
        fails++; $display("FAIL ovf16_restart: got %b %h/%b want 1 %h/%b", out_valid16, data_out16, ovf16, e.data[31:0], e.ovf);
      end
    end
  endtask

  task automatic test_reset_inflight();
    bit ok, got;
    int lat, seen;
    exp_t e;
    @(negedge clk); acc_clr = 1'b1;
    @(negedge clk); acc_clr = 1'b0;
    sb.push_back('{64'hE0C, 1'b0});
    drive_one(32'h04030201, 2'd2, ok);
    wait_out(got, lat);
    if (sb.size() > 0) e = sb.pop_front(); else e = '1;
    checks++; if (!got || data_out !== e.data) begin fails++; $display("FAIL rst_preload: got %h want %h", data_out, e.data); end
    @(negedge clk);
    in_valid = 1'b1; mode = 2'd0; data_in = 32'h00010002;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rst_inflight_pre: out_valid %b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_async_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_async_ready: got %b want 0", in_ready); end
    checks++; if (data_out !== 64'h0 || ovf !== 1'b0) begin fails++; $display("FAIL rst_async_data: got %h/%b want 0/0", data_out, ovf); end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (8) begin @(negedge clk); if (out_valid === 1'b1) seen++; end
    checks++; if (seen != 0) begin fails++; $display("FAIL rst_ghost: %0d outputs after release want 0", seen); end
    sb.push_back('{64'hE0C, 1'b0});
    drive_one(32'h04030201, 2'd2, ok);
    wait_out(got, lat);
    if (sb.size() > 0) e = sb.pop_front(); else e = '1;
    checks++;
    if (!got || data_out !== e.data || ovf !== e.ovf) begin
      fails++; $display("FAIL rst_first_after: got %b %h/%b want %h/%b", got, data_out, ovf, e.data, e.ovf);
    end
  endtask

  initial begin
    in_valid = 1'b0; data_in = 32'h0; mode = 2'd0; acc_clr = 1'b0; out_ready = 1'b1;
    in_valid16 = 1'b0; data_in16 = 16'h0; mode16 = 2'd0; acc_clr16 = 1'b0; out_ready16 = 1'b1;
    test_reset();
    test_modes();
    test_back_to_back();
    test_accumulate();
    test_overflow16();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
